// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Lets the instruction-fetch port and the data port share one single-port
// 16-bit memory. One access runs at a time. Each access goes
// IDLE -> ISSUE -> (WAIT) -> DONE. pipe_stall holds the core while any
// request is still waiting for its ready pulse.

module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ready,
    output logic        pipe_stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [15:0] stall_cnt,
    output logic        err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_D   = 1'b1;
    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        kind_q, kind_d;
    logic        last_owner_q, last_owner_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_re_q, mem_re_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] d_rdata_q, d_rdata_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        err_q, err_d;

    logic        d_req;
    logic        pick_d;

    assign d_req = d_read | d_write;

    // Round-robin choice: on a tie the port that did not own the last access wins
    always_comb begin
        pick_d = 1'b0;
        if (if_req && d_req) begin
            pick_d = (last_owner_q == OWN_IF);
        end else begin
            pick_d = d_req;
        end
    end

    // Access sequencer: grants in IDLE, strobes in ISSUE, counts latency in WAIT
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        kind_d       = kind_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d = ST_ISSUE;
                    if (pick_d) begin
                        owner_d     = OWN_D;
                        kind_d      = d_write ? KIND_WR : KIND_RD;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_we_d    = d_write;
                        mem_re_d    = ~d_write;
                        err_d       = err_q | (d_read & d_write);
                    end else begin
                        owner_d    = OWN_IF;
                        kind_d     = KIND_RD;
                        mem_addr_d = if_addr;
                        mem_re_d   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (kind_q == KIND_RD) begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    if (owner_q == OWN_D) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            default: begin
                last_owner_d = owner_q;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // Saturating count of stalled cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pipe_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers; reset abandons any access in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            kind_q       <= KIND_RD;
            last_owner_q <= OWN_IF;
            cnt_q        <= 4'd0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 16'd0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            if_rdata_q   <= 16'd0;
            d_rdata_q    <= 16'd0;
            stall_cnt_q  <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            kind_q       <= kind_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_re_q     <= mem_re_d;
            mem_we_q     <= mem_we_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            stall_cnt_q  <= stall_cnt_d;
            err_q        <= err_d;
        end
    end

    assign if_ready   = (state_q == ST_DONE) && (owner_q == OWN_IF);
    assign d_ready    = (state_q == ST_DONE) && (owner_q == OWN_D);
    assign pipe_stall = (if_req & ~if_ready) | (d_req & ~d_ready);
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign stall_cnt  = stall_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter with directed and random core traffic. A
// latency-MEM_LAT memory model answers the strobes. A transaction-level
// timeline predicts every output cycle by cycle.

module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        d_read;
    logic        d_write;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        pipe_stall;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic [15:0] stall_cnt;
    logic        err;

    int checkCount = 0;
    int passCount  = 0;

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ready   (if_ready),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ready    (d_ready),
        .pipe_stall (pipe_stall),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata),
        .stall_cnt  (stall_cnt),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Power-on / reset contents of the memory, shared by memory model and predictor
    function automatic logic [15:0] patWord(input int i);
        logic [15:0] w;
        if (i == 4) return 16'hA123;
        w = 16'(i) * 16'h1357;
        return w ^ 16'hC3C3;
    endfunction

    // Memory model: data appears LAT cycles after the edge that samples mem_re
    logic [15:0] envMem [0:255];
    int          envCnt  = 0;
    logic [15:0] envPend = 16'h0000;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) envMem[i] <= patWord(i);
        end else if (mem_we) begin
            envMem[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_re) begin
            envPend <= envMem[mem_addr[7:0]];
            envCnt  <= LAT;
        end else if (envCnt > 0) begin
            envCnt <= envCnt - 1;
        end
    end

    assign mem_rdata = (envCnt == 1) ? envPend : 16'hDEAD;

    // Predictor state: timeline of the single access in flight
    int          cyc        = 0;
    bit          active     = 0;
    bit          postReset  = 0;
    int          freeCyc    = 0;
    int          readyCyc   = -1;
    int          strobeCyc  = -1;
    bit          expOwner   = 0;
    bit          expWrite   = 0;
    bit          lastOwner  = 0;
    logic [15:0] expWdata   = 16'h0;
    logic [15:0] expData    = 16'h0;
    logic [15:0] expMemAddr = 16'h0;
    logic [15:0] expIfRdata = 16'h0;
    logic [15:0] expDRdata  = 16'h0;
    logic [15:0] expStallCnt = 16'h0;
    bit          expErr     = 0;
    logic [15:0] refMem [0:255];

    int lastIfReadyCyc = -100;
    int lastDReadyCyc  = -100;
    int readyLog[$];

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h at cycle %0d", tag, actual, expected, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the timeline, advance the timeline
    task automatic applyStimulus(input logic rst, input logic ir, input logic [15:0] ia,
                                 input logic dr, input logic dw, input logic [15:0] da,
                                 input logic [15:0] dd);
        bit expIfReady;
        bit expDReady;
        bit expStall;
        bit pickD;
        bit dReq;
        reset   = rst;
        if_req  = ir;
        if_addr = ia;
        d_read  = dr;
        d_write = dw;
        d_addr  = da;
        d_wdata = dd;
        #1;
        dReq       = dr | dw;
        expIfReady = active && (readyCyc == cyc) && !expOwner;
        expDReady  = active && (readyCyc == cyc) && expOwner;
        expStall   = (ir && !expIfReady) || (dReq && !expDReady);
        if (active) begin
            checkOutput("if_ready", 16'(if_ready), 16'(expIfReady));
            checkOutput("d_ready", 16'(d_ready), 16'(expDReady));
            checkOutput("mem_re", 16'(mem_re), 16'((strobeCyc == cyc) && !expWrite));
            checkOutput("mem_we", 16'(mem_we), 16'((strobeCyc == cyc) && expWrite));
            checkOutput("mem_addr", mem_addr, expMemAddr);
            if ((strobeCyc == cyc) && expWrite) checkOutput("mem_wdata", mem_wdata, expWdata);
            if (postReset) checkOutput("mem_wdata_rst", mem_wdata, 16'h0000);
            checkOutput("if_rdata", if_rdata, expIfRdata);
            checkOutput("d_rdata", d_rdata, expDRdata);
            checkOutput("pipe_stall", 16'(pipe_stall), 16'(expStall));
            checkOutput("stall_cnt", stall_cnt, expStallCnt);
            checkOutput("err", 16'(err), 16'(expErr));
        end
        if (if_ready) begin
            lastIfReadyCyc = cyc;
            readyLog.push_back(0);
        end
        if (d_ready) begin
            lastDReadyCyc = cyc;
            readyLog.push_back(1);
        end
        if (rst) begin
            active      = 1;
            postReset   = 1;
            freeCyc     = cyc + 1;
            readyCyc    = -1;
            strobeCyc   = -1;
            lastOwner   = 0;
            expOwner    = 0;
            expWrite    = 0;
            expStallCnt = 16'h0;
            expErr      = 0;
            expIfRdata  = 16'h0;
            expDRdata   = 16'h0;
            expMemAddr  = 16'h0;
            for (int i = 0; i < 256; i++) refMem[i] = patWord(i);
        end else if (active) begin
            postReset = 0;
            if (expStall && (expStallCnt != 16'hFFFF)) expStallCnt = expStallCnt + 16'd1;
            if ((cyc + 1 == readyCyc) && !expWrite) begin
                if (expOwner) expDRdata = expData;
                else expIfRdata = expData;
            end
            if ((cyc >= freeCyc) && (ir || dReq)) begin
                pickD     = (ir && dReq) ? (lastOwner == 0) : dReq;
                lastOwner = pickD;
                expOwner  = pickD;
                if (pickD) begin
                    expWrite   = dw;
                    expMemAddr = da;
                    expErr     = expErr | (dr & dw);
                    if (dw) begin
                        expWdata          = dd;
                        refMem[da[7:0]]   = dd;
                    end else begin
                        expData = refMem[da[7:0]];
                    end
                end else begin
                    expWrite   = 0;
                    expMemAddr = ia;
                    expData    = refMem[ia[7:0]];
                end
                strobeCyc = cyc + 1;
                readyCyc  = cyc + (expWrite ? 2 : LAT + 2);
                freeCyc   = readyCyc + 1;
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    int  startCyc;
    bit  ifAct, dAct, dWr;
    logic [15:0] ifA, dA, dD;

    // Directed scenarios followed by random traffic
    initial begin
        reset = 1; if_req = 0; if_addr = 0; d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
        @(negedge clock);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);

        startCyc = cyc;
        for (int k = 0; k < LAT + 3; k++) applyStimulus(0, 1, 16'h0004, 0, 0, 16'h0, 16'h0);
        checkOutput("rd_latency", 16'(lastIfReadyCyc - startCyc), 16'(LAT + 2));
        idleCycles(1);
        checkOutput("rd_data_hold", if_rdata, 16'hA123);

        startCyc = cyc;
        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 16'h0, 0, 1, 16'h0010, 16'h5A5A);
        checkOutput("wr_latency", 16'(lastDReadyCyc - startCyc), 16'd2);
        for (int k = 0; k < LAT + 3; k++) applyStimulus(0, 0, 16'h0, 1, 0, 16'h0010, 16'h0);
        idleCycles(1);
        checkOutput("readback", d_rdata, 16'h5A5A);

        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        readyLog.delete();
        for (int k = 0; k < 4 * (LAT + 3); k++) applyStimulus(0, 1, 16'h0008, 1, 0, 16'h000C, 16'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("grant_order", (readyLog.size() > i) ? 16'(readyLog[i]) : 16'hFFFF,
                        (i % 2 == 0) ? 16'd1 : 16'd0);
        end
        idleCycles(1);

        readyLog.delete();
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 16'h0006, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 16'h0, 0, 0, 16'h0, 16'h0);
        idleCycles(LAT + 3);
        checkOutput("abort_no_ready", 16'(readyLog.size()), 16'd0);
        for (int k = 0; k < LAT + 3; k++) applyStimulus(0, 1, 16'h0004, 0, 0, 16'h0, 16'h0);
        idleCycles(1);
        checkOutput("post_abort_read", if_rdata, 16'hA123);

        for (int k = 0; k < 3; k++) applyStimulus(0, 0, 16'h0, 1, 1, 16'h0020, 16'h1234);
        checkOutput("err_set", 16'(err), 16'd1);
        idleCycles(5);
        checkOutput("err_sticky", 16'(err), 16'd1);
        for (int k = 0; k < LAT + 3; k++) applyStimulus(0, 0, 16'h0, 1, 0, 16'h0020, 16'h0);
        idleCycles(1);
        checkOutput("illegal_wr_data", d_rdata, 16'h1234);

        force dut.stall_cnt_q = 16'hFFFD;
        #1;
        release dut.stall_cnt_q;
        expStallCnt = 16'hFFFD;
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 16'h0002, 1, 0, 16'h0003, 16'h0);
        checkOutput("stall_sat", stall_cnt, 16'hFFFF);
        idleCycles(2 * (LAT + 3));

        ifAct = 0; dAct = 0; dWr = 0; ifA = 0; dA = 0; dD = 0;
        for (int k = 0; k < 400; k++) begin
            if (ifAct && (readyCyc == cyc - 1) && !expOwner) ifAct = 0;
            if (dAct && (readyCyc == cyc - 1) && expOwner) dAct = 0;
            if (!ifAct && ($urandom_range(0, 2) == 0)) begin
                ifAct = 1;
                ifA   = 16'($urandom_range(0, 31));
            end
            if (!dAct && ($urandom_range(0, 2) == 0)) begin
                dAct = 1;
                dWr  = ($urandom_range(0, 1) == 1);
                dA   = 16'($urandom_range(0, 31));
                dD   = 16'($urandom);
            end
            applyStimulus(0, ifAct, ifA, dAct && !dWr, dAct && dWr, dA, dD);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
